// File: rtl/pipe_hazard_ctrl_if.sv
// Handshake bundle between the 5-stage pipeline datapath and its sequencing controller.
//   master : pipeline side, drives ID/EX/MEM status and consumes the stage controls
//   slave  : controller side (pipe_hazard_ctrl)
// Signals:
//   id_*        ID-stage source registers and validity
//   ex_*        EX-stage load/branch/condition info, alu_flags = EX ALU {N,Z,C,V}
//   mem_*       MEM-stage access in flight and data memory acknowledge
//   *_we        stage register / PC write enables
//   pc_sel_br   PC loads branch target
//   if_id_flush, id_ex_bubble  NOP insertion controls
//   br_taken, flags, mem_err, stall_cnt, flush_cnt  status and counters
interface pipe_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [3:0]       id_rn;
  logic [3:0]       id_rm;
  logic             id_uses_rm;
  logic             id_valid;
  logic             ex_valid;
  logic             ex_is_load;
  logic [3:0]       ex_rd;
  logic             ex_is_branch;
  logic [3:0]       ex_cond;
  logic             ex_set_cond;
  logic [3:0]       alu_flags;
  logic             mem_access;
  logic             mem_ack;

  logic             pc_we;
  logic             pc_sel_br;
  logic             if_id_we;
  logic             if_id_flush;
  logic             id_ex_we;
  logic             id_ex_bubble;
  logic             ex_mem_we;
  logic             mem_wb_we;
  logic             br_taken;
  logic [3:0]       flags;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rn, id_rm, id_uses_rm, id_valid, ex_valid, ex_is_load, ex_rd, ex_is_branch,
           ex_cond, ex_set_cond, alu_flags, mem_access, mem_ack,
    input  pc_we, pc_sel_br, if_id_we, if_id_flush, id_ex_we, id_ex_bubble, ex_mem_we,
           mem_wb_we, br_taken, flags, mem_err, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rn, id_rm, id_uses_rm, id_valid, ex_valid, ex_is_load, ex_rd, ex_is_branch,
           ex_cond, ex_set_cond, alu_flags, mem_access, mem_ack,
    output pc_we, pc_sel_br, if_id_we, if_id_flush, id_ex_we, id_ex_bubble, ex_mem_we,
           mem_wb_we, br_taken, flags, mem_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller for the IF/ID/EX/MEM/WB ARM-subset pipeline.
// Holds the NZCV flags, resolves EX-stage conditional branches, load-use stalls and
// data-memory wait freezes, and flags a sticky error when memory never acknowledges.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    pipe_hazard_ctrl_if.slave (pipeline status in, stage controls/status out)
// Parameters:
//   MEM_TIMEOUT  consecutive frozen cycles tolerated before entering the error state
//   CNT_W        width of the saturating stall/flush counters
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 16
) (
  input logic               clk,
  input logic               rst_n,
  pipe_hazard_ctrl_if.slave bus
);

  localparam int unsigned WaitW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {StRun, StWait, StErr} state_e;

  state_e           state_q, state_d;
  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
  logic [3:0]       flags_q, flags_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic freeze, active, cond_true, br_taken, load_use, stall_evt;
  logic flag_n, flag_z, flag_c, flag_v;

  assign {flag_n, flag_z, flag_c, flag_v} = flags_q;
  assign freeze = bus.mem_access & ~bus.mem_ack;
  assign active = (state_q != StErr);

  // Branches test the architectural flags, not this cycle's ALU result.
  always_comb begin
    cond_true = 1'b0;
    case (bus.ex_cond)
      4'b0000: cond_true = flag_z;
      4'b0001: cond_true = ~flag_z;
      4'b0010: cond_true = flag_c;
      4'b0011: cond_true = ~flag_c;
      4'b0100: cond_true = flag_n;
      4'b0101: cond_true = ~flag_n;
      4'b0110: cond_true = flag_v;
      4'b0111: cond_true = ~flag_v;
      4'b1000: cond_true = flag_c & ~flag_z;
      4'b1001: cond_true = ~flag_c | flag_z;
      4'b1010: cond_true = (flag_n == flag_v);
      4'b1011: cond_true = (flag_n != flag_v);
      4'b1100: cond_true = ~flag_z & (flag_n == flag_v);
      4'b1101: cond_true = flag_z | (flag_n != flag_v);
      4'b1110: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

  assign br_taken = rst_n & active & ~freeze & bus.ex_valid & bus.ex_is_branch & cond_true;

  assign load_use = bus.ex_valid & bus.ex_is_load & bus.id_valid &
                    ((bus.ex_rd == bus.id_rn) | (bus.id_uses_rm & (bus.ex_rd == bus.id_rm)));

  // A load-use hit is moot when the ID instruction is being flushed by a taken branch.
  assign stall_evt = active & (freeze | (load_use & ~br_taken));

  always_comb begin
    bus.pc_we        = 1'b0;
    bus.pc_sel_br    = 1'b0;
    bus.if_id_we     = 1'b0;
    bus.if_id_flush  = 1'b0;
    bus.id_ex_we     = 1'b0;
    bus.id_ex_bubble = 1'b0;
    bus.ex_mem_we    = 1'b0;
    bus.mem_wb_we    = 1'b0;
    if (!rst_n) begin
      bus.if_id_flush  = 1'b1;
      bus.id_ex_bubble = 1'b1;
    end else if (active && !freeze) begin
      bus.pc_we     = 1'b1;
      bus.if_id_we  = 1'b1;
      bus.id_ex_we  = 1'b1;
      bus.ex_mem_we = 1'b1;
      bus.mem_wb_we = 1'b1;
      if (br_taken) begin
        bus.pc_sel_br    = 1'b1;
        bus.if_id_flush  = 1'b1;
        bus.id_ex_bubble = 1'b1;
      end else if (load_use) begin
        // Hold PC and IF/ID; ID/EX takes a bubble while older stages drain.
        bus.pc_we        = 1'b0;
        bus.if_id_we     = 1'b0;
        bus.id_ex_bubble = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    flags_d     = flags_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    unique case (state_q)
      StRun: begin
        if (freeze) begin
          if (MEM_TIMEOUT <= 1) begin
            state_d = StErr;
          end else begin
            state_d    = StWait;
            wait_cnt_d = WaitW'(1);
          end
        end
      end
      StWait: begin
        // wait_cnt_q counts frozen cycles already spent; this one makes it +1.
        if (!freeze) begin
          state_d = StRun;
        end else if (wait_cnt_q >= WaitW'(MEM_TIMEOUT - 1)) begin
          state_d = StErr;
        end else begin
          wait_cnt_d = wait_cnt_q + WaitW'(1);
        end
      end
      StErr:   state_d = StErr;
      default: state_d = StRun;
    endcase

    mem_err_d = mem_err_q | (state_d == StErr);

    if (active && !freeze && bus.ex_valid && bus.ex_set_cond) begin
      flags_d = bus.alu_flags;
    end
    if (stall_evt && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (br_taken && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StRun;
      wait_cnt_q  <= '0;
      flags_q     <= 4'b0000;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      flags_q     <= flags_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.br_taken  = br_taken;
  assign bus.flags     = flags_q;
  assign bus.mem_err   = mem_err_q;
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios with literal expectations
// followed by randomized traffic, all checked every cycle against a behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int unsigned MEM_TIMEOUT = 16;
  // Narrow counters so saturation is reachable in a short run.
  localparam int unsigned CNT_W       = 6;
  localparam int unsigned CNT_MAX     = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) b ();

  pipe_hazard_ctrl #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (b)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic pc_we, pc_sel_br, if_id_we, if_id_flush, id_ex_we, id_ex_bubble;
    logic ex_mem_we, mem_wb_we, br_taken, stall_evt;
  } exp_t;

  bit          m_err   = 1'b0;
  int unsigned m_run   = 0;   // consecutive frozen cycles so far
  logic [3:0]  m_flags = 4'b0;
  int unsigned m_stall = 0;
  int unsigned m_flush = 0;
  exp_t        e_now;

  // ARM conditions come in pairs: odd codes are the negation of the even one below them.
  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    {n, z, cy, v} = f;
    case (c[3:1])
      3'd0:    base = z;
      3'd1:    base = cy;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = cy && !z;
      3'd5:    base = (n == v);
      3'd6:    base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    logic fz, hit;
    e   = '0;
    fz  = b.mem_access && !b.mem_ack;
    hit = b.ex_valid && b.ex_is_load && b.id_valid &&
          (b.ex_rd == b.id_rn || (b.id_uses_rm && b.ex_rd == b.id_rm));
    if (!rst_n) begin
      e.if_id_flush  = 1'b1;
      e.id_ex_bubble = 1'b1;
    end else if (!m_err) begin
      if (fz) begin
        e.stall_evt = 1'b1;
      end else begin
        e.br_taken  = b.ex_valid && b.ex_is_branch && cond_ok(b.ex_cond, m_flags);
        e.pc_we     = 1'b1;
        e.if_id_we  = 1'b1;
        e.id_ex_we  = 1'b1;
        e.ex_mem_we = 1'b1;
        e.mem_wb_we = 1'b1;
        if (e.br_taken) begin
          e.pc_sel_br    = 1'b1;
          e.if_id_flush  = 1'b1;
          e.id_ex_bubble = 1'b1;
        end else if (hit) begin
          e.pc_we        = 1'b0;
          e.if_id_we     = 1'b0;
          e.id_ex_bubble = 1'b1;
          e.stall_evt    = 1'b1;
        end
      end
    end
    return e;
  endfunction

  always_comb e_now = model_out();

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_err   <= 1'b0;
      m_run   <= 0;
      m_flags <= 4'b0;
      m_stall <= 0;
      m_flush <= 0;
    end else if (!m_err) begin
      if (b.mem_access && !b.mem_ack) begin
        m_run <= m_run + 1;
        if (m_run + 1 >= MEM_TIMEOUT) m_err <= 1'b1;
      end else begin
        m_run <= 0;
        if (b.ex_valid && b.ex_set_cond) m_flags <= b.alu_flags;
      end
      if (e_now.stall_evt) m_stall <= (m_stall >= CNT_MAX) ? CNT_MAX : m_stall + 1;
      if (e_now.br_taken)  m_flush <= (m_flush >= CNT_MAX) ? CNT_MAX : m_flush + 1;
    end
  end

  // Compare process: every falling edge, all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ctrl", {b.pc_we, b.pc_sel_br, b.if_id_we, b.if_id_flush, b.id_ex_we,
                   b.id_ex_bubble, b.ex_mem_we, b.mem_wb_we, b.br_taken},
                  {e_now.pc_we, e_now.pc_sel_br, e_now.if_id_we, e_now.if_id_flush,
                   e_now.id_ex_we, e_now.id_ex_bubble, e_now.ex_mem_we, e_now.mem_wb_we,
                   e_now.br_taken});
      chk("flags", b.flags, m_flags);
      chk("mem_err", b.mem_err, m_err);
      chk("stall_cnt", b.stall_cnt, m_stall);
      chk("flush_cnt", b.flush_cnt, m_flush);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    b.id_rn = 4'd0; b.id_rm = 4'd0; b.id_uses_rm = 1'b0; b.id_valid = 1'b0;
    b.ex_valid = 1'b0; b.ex_is_load = 1'b0; b.ex_rd = 4'd0; b.ex_is_branch = 1'b0;
    b.ex_cond = 4'd0; b.ex_set_cond = 1'b0; b.alu_flags = 4'd0;
    b.mem_access = 1'b0; b.mem_ack = 1'b0;
  endtask

  task automatic half();
    @(negedge clk);
    #1;
  endtask

  task automatic fin();
    @(posedge clk);
    #1;
  endtask

  // Called one time unit after a rising edge; asserts reset mid-cycle.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_flush", b.if_id_flush, 1);
    chk("rst_bubble", b.id_ex_bubble, 1);
    chk("rst_we", {b.pc_we, b.if_id_we, b.id_ex_we, b.ex_mem_we, b.mem_wb_we}, 0);
    chk("rst_br", {b.pc_sel_br, b.br_taken}, 0);
    chk("rst_flags", b.flags, 0);
    chk("rst_mem_err", b.mem_err, 0);
    chk("rst_cnts", {b.stall_cnt, b.flush_cnt}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  int dead;

  initial begin
    rst_n = 1'b1;
    idle();
    fin();
    chk_en = 1'b1;
    do_reset();

    // Flag set then EQ/NE branches.
    b.ex_valid = 1'b1; b.ex_set_cond = 1'b1; b.alu_flags = 4'b0100;
    half(); chk("pre_br", b.br_taken, 0); fin();
    b.ex_set_cond = 1'b0; b.alu_flags = 4'b0000; b.ex_is_branch = 1'b1; b.ex_cond = 4'b0000;
    half();
    chk("eq_flags", b.flags, 4'b0100);
    chk("eq_taken", {b.br_taken, b.pc_sel_br, b.pc_we, b.if_id_flush, b.id_ex_bubble}, 5'b11111);
    fin();
    chk("eq_flush_cnt", b.flush_cnt, 1);
    b.ex_cond = 4'b0001;
    half(); chk("ne_taken", {b.br_taken, b.pc_sel_br, b.if_id_flush}, 3'b000); fin();
    chk("ne_flush_cnt", b.flush_cnt, 1);

    // Load-use on rn, then rm with and without id_uses_rm.
    idle();
    b.ex_valid = 1'b1; b.ex_is_load = 1'b1; b.ex_rd = 4'd3; b.id_valid = 1'b1; b.id_rn = 4'd3;
    half(); chk("lu_stall", {b.pc_we, b.if_id_we, b.id_ex_bubble, b.ex_mem_we}, 4'b0011); fin();
    b.ex_valid = 1'b0; b.ex_is_load = 1'b0;
    half(); chk("lu_release", {b.pc_we, b.id_ex_bubble}, 2'b10);
    chk("lu_stall_cnt", b.stall_cnt, 1); fin();
    b.ex_valid = 1'b1; b.ex_is_load = 1'b1; b.id_rn = 4'd5; b.id_rm = 4'd3; b.id_uses_rm = 1'b0;
    half(); chk("rm_imm", b.pc_we, 1); fin();
    b.id_uses_rm = 1'b1;
    half(); chk("rm_reg", b.pc_we, 0); fin();
    chk("rm_stall_cnt", b.stall_cnt, 2);

    // Load-use hit with a taken branch in the same cycle.
    b.id_rn = 4'd3; b.ex_is_branch = 1'b1; b.ex_cond = 4'b1110;
    half(); chk("lu_br", {b.br_taken, b.pc_we, b.if_id_we, b.id_ex_bubble}, 4'b1111); fin();
    chk("lu_br_stall_cnt", b.stall_cnt, 2);

    // Three-cycle memory wait, flags held while frozen.
    do_reset();
    idle();
    b.mem_access = 1'b1; b.ex_valid = 1'b1; b.ex_set_cond = 1'b1; b.alu_flags = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      half();
      chk("frz_we", {b.pc_we, b.if_id_we, b.id_ex_we, b.ex_mem_we, b.mem_wb_we, b.br_taken}, 0);
      fin();
    end
    b.mem_ack = 1'b1;
    half();
    chk("ack_we", {b.pc_we, b.mem_wb_we}, 2'b11);
    chk("ack_stall_cnt", b.stall_cnt, 3);
    chk("ack_flags_held", b.flags, 0);
    fin();
    chk("ack_flags_upd", b.flags, 4'b1111);
    idle();
    half(); chk("run_after_ack", b.pc_we, 1); fin();

    // Timeout: never acknowledge.
    do_reset();
    idle();
    b.mem_access = 1'b1;
    for (int i = 0; i < 16; i++) begin
      half(); chk("to_pending", b.mem_err, 0); fin();
    end
    half(); chk("to_err", b.mem_err, 1); chk("to_stall_cnt", b.stall_cnt, 16); fin();
    b.mem_access = 1'b0;
    repeat (3) fin();
    half(); chk("to_sticky", {b.mem_err, b.pc_we}, 2'b10); fin();

    // Reset in the middle of a wait, with non-zero flags.
    do_reset();
    idle();
    b.ex_valid = 1'b1; b.ex_set_cond = 1'b1; b.alu_flags = 4'b1010;
    fin();
    idle();
    b.mem_access = 1'b1;
    half(); chk("mid_flags", b.flags, 4'b1010); fin();
    fin();
    do_reset();
    idle();
    half(); chk("mid_run", b.pc_we, 1); fin();

    // Saturation of both counters.
    b.ex_valid = 1'b1; b.ex_is_load = 1'b1; b.ex_rd = 4'd2; b.id_valid = 1'b1; b.id_rn = 4'd2;
    repeat (70) fin();
    chk("stall_sat", b.stall_cnt, CNT_MAX);
    b.ex_is_branch = 1'b1; b.ex_cond = 4'b1110;
    repeat (70) fin();
    chk("flush_sat", b.flush_cnt, CNT_MAX);
    chk("stall_sat_hold", b.stall_cnt, CNT_MAX);

    // Randomized traffic.
    do_reset();
    dead = 0;
    for (int i = 0; i < 3000; i++) begin
      b.id_rn        = 4'($urandom_range(0, 3));
      b.id_rm        = 4'($urandom_range(0, 3));
      b.ex_rd        = 4'($urandom_range(0, 3));
      b.id_uses_rm   = 1'($urandom_range(0, 1));
      b.id_valid     = ($urandom_range(0, 4) != 0);
      b.ex_valid     = ($urandom_range(0, 4) != 0);
      b.ex_is_load   = ($urandom_range(0, 2) == 0);
      b.ex_is_branch = ($urandom_range(0, 3) == 0);
      b.ex_cond      = 4'($urandom_range(0, 15));
      b.ex_set_cond  = ($urandom_range(0, 4) < 2);
      b.alu_flags    = 4'($urandom_range(0, 15));
      if (dead == 0 && $urandom_range(0, 299) == 0) dead = $urandom_range(10, 20);
      if (dead > 0) begin
        b.mem_access = 1'b1;
        b.mem_ack    = 1'b0;
        dead--;
      end else begin
        b.mem_access = ($urandom_range(0, 2) == 0);
        b.mem_ack    = ($urandom_range(0, 2) != 0);
      end
      if (i % 500 == 499) do_reset();
      else fin();
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
